// File: rtl/dma_req_fifo_arbiter.sv
// dma_req_fifo_arbiter
// Round-robin push-side arbiter in front of the 16-deep x 28-bit FIFO.
// Four requesters offer 26-bit entries on valid/ready; one requester is
// granted for a burst of up to BURST_MAX beats, each entry is tagged with
// its 2-bit source ID and pushed one cycle after it is accepted.
// Acceptance is throttled on FIFO occupancy plus the push in flight, so a
// push can never land on a full FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; arbitrate among valid requesters starting after lastGrant
// BURST | grantIdx owns the push port; accept beats until BURST_MAX or drop
module dma_req_fifo_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic         clockCore,
  input  logic         resetCore,
  input  logic [3:0]   reqValid,
  input  logic [103:0] reqData,
  output logic [3:0]   reqReady,
  output logic         fifoPush,
  output logic [27:0]  fifoDataIn,
  input  logic [4:0]   fifoDepth,
  input  logic         fifoOverrun,
  input  logic         fifoUnderrun,
  output logic [4:0]   almostFullThreshold,
  output logic [4:0]   almostEmptyThreshold,
  input  logic         errClear,
  output logic         errOverrun,
  output logic         errUnderrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbStateT;

  // Beat index of the final beat of a burst.
  localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

  arbStateT    state;
  arbStateT    stateNext;
  logic [1:0]  grantIdx;
  logic [1:0]  grantIdxNext;
  logic [1:0]  lastGrant;
  logic [1:0]  lastGrantNext;
  logic [3:0]  beatCnt;
  logic [3:0]  beatCntNext;

  logic [5:0]  pushSum;
  logic        throttle;
  logic        accept;
  logic [1:0]  selIdx;
  logic        selFound;
  logic [25:0] reqWord [4];
  logic [25:0] grantData;

  // Occupancy check counts the registered push that has not landed yet;
  // pops are ignored so the check can only err on the safe side.
  always_comb begin
    pushSum  = {1'b0, fifoDepth} + {5'b0_0000, fifoPush};
    throttle = (pushSum >= 6'd16);
  end

  // Split the flat request bus into per-requester words and select the
  // word of the current grant for the push path.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reqWord[i] = reqData[26*i +: 26];
    end
    grantData = reqWord[grantIdx];
  end

  // Round-robin pick: first valid requester at lastGrant+1 .. lastGrant+4.
  always_comb begin
    logic [1:0] cand;
    selIdx   = lastGrant + 2'd1;
    selFound = 1'b0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = lastGrant + 2'(k);
      if (!selFound && reqValid[cand]) begin
        selIdx   = cand;
        selFound = 1'b1;
      end
    end
  end

  // FSM next-state, grant bookkeeping and ready outputs.
  always_comb begin
    stateNext     = state;
    grantIdxNext  = grantIdx;
    lastGrantNext = lastGrant;
    beatCntNext   = beatCnt;
    reqReady      = 4'b0000;
    accept        = 1'b0;

    unique case (state)
      IDLE: begin
        if (selFound && !throttle) begin
          grantIdxNext = selIdx;
          beatCntNext  = 4'd0;
          stateNext    = BURST;
        end
      end

      BURST: begin
        reqReady[grantIdx] = !throttle;
        if (!reqValid[grantIdx]) begin
          // A dropped valid is only legal at end of burst; close it here.
          lastGrantNext = grantIdx;
          stateNext     = IDLE;
        end else if (!throttle) begin
          accept      = 1'b1;
          beatCntNext = beatCnt + 4'd1;
          if (beatCnt == BEAT_LAST) begin
            lastGrantNext = grantIdx;
            stateNext     = IDLE;
          end
        end
        // Throttled with valid high: hold the grant, stall is not a beat.
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state     <= IDLE;
      grantIdx  <= 2'd0;
      lastGrant <= 2'd3;
      beatCnt   <= 4'd0;
    end else begin
      state     <= stateNext;
      grantIdx  <= grantIdxNext;
      lastGrant <= lastGrantNext;
      beatCnt   <= beatCntNext;
    end
  end

  // Push path: an accepted entry is tagged and presented the next cycle;
  // data holds between pushes.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      fifoPush   <= 1'b0;
      fifoDataIn <= 28'd0;
    end else begin
      fifoPush <= accept;
      if (accept) begin
        fifoDataIn <= {grantIdx, grantData};
      end
    end
  end

  // Sticky error flags; a new pulse wins over a simultaneous clear.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      errOverrun  <= 1'b0;
      errUnderrun <= 1'b0;
    end else begin
      if (fifoOverrun) begin
        errOverrun <= 1'b1;
      end else if (errClear) begin
        errOverrun <= 1'b0;
      end
      if (fifoUnderrun) begin
        errUnderrun <= 1'b1;
      end else if (errClear) begin
        errUnderrun <= 1'b0;
      end
    end
  end

  // Threshold constants for the FIFO status logic.
  assign almostFullThreshold  = 5'(AF_THRESH);
  assign almostEmptyThreshold = 5'(AE_THRESH);

endmodule

// File: doc/dma_req_fifo_arbiter.md
# dma_req_fifo_arbiter

Round-robin push-side arbiter for the 16-deep x 28-bit register FIFO. Four DMA requesters each offer 26-bit entries on a valid/ready handshake. The block grants one requester at a time for a bounded burst, tags each entry with a 2-bit source ID and drives the FIFO push port. It throttles on FIFO occupancy so the FIFO never overruns.

## Interface
- BURST_MAX, 4: max beats accepted per grant (1..15).
- AF_THRESH, 14: value driven on almostFullThreshold.
- AE_THRESH, 2: value driven on almostEmptyThreshold.
- clockCore  in  1  core clock, all state on rising edge.
- resetCore  in  1  asynchronous active-low reset.
- reqValid  in  4  per-requester entry valid.
- reqData  in  104  entries; requester i uses [26i+25:26i].
- reqReady  out  4  per-requester ready; accept = reqValid[i] & reqReady[i].
- fifoPush  out  1  FIFO push strobe.
- fifoDataIn  out  28  {srcId[1:0], data[25:0]}.
- fifoDepth  in  5  FIFO occupancy, 0..16.
- fifoOverrun  in  1  FIFO overrun pulse.
- fifoUnderrun  in  1  FIFO underrun pulse.
- almostFullThreshold  out  5  constant AF_THRESH.
- almostEmptyThreshold  out  5  constant AE_THRESH.
- errClear  in  1  clears sticky error flags.
- errOverrun  out  1  sticky, set by fifoOverrun.
- errUnderrun  out  1  sticky, set by fifoUnderrun.

## Operation
- Registers:
  - state: IDLE or BURST.
  - grantIdx[1:0].
  - lastGrant[1:0], reset value 3.
  - beatCnt[3:0].
  - fifoPush, fifoDataIn.
  - error flags.
- throttle = ({1'b0,fifoDepth} + fifoPush) >= 16, computed as a 6-bit sum. Pops are ignored, which makes the check conservative. Accepting only when the sum is ≤15 guarantees that a push never lands on a full FIFO.
- IDLE:
  - reqReady = 0.
  - If any reqValid is high and throttle is low: pick the first valid requester in order lastGrant+1, +2, +3, +4 (mod 4), load grantIdx, clear beatCnt, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - reqReady[grantIdx] = !throttle; all other bits 0. reqReady is combinational from registered state, fifoDepth and fifoPush.
  - On accept: beatCnt++. If beatCnt == BURST_MAX-1, set lastGrant = grantIdx and go to IDLE.
  - If reqValid[grantIdx] is low: no accept, set lastGrant = grantIdx, go to IDLE.
  - If throttle is high and reqValid[grantIdx] is high: hold BURST with no accept. The throttle stall does not count toward BURST_MAX.
- Push path: an accept in cycle t registers fifoPush = 1 and fifoDataIn = {grantIdx, reqData[grantIdx]} for cycle t+1. With no accept, fifoPush = 0 and fifoDataIn holds its previous value.
- Error flags:
  - Set on the input pulse.
  - Cleared by errClear.
  - Set wins when set and errClear occur in the same cycle.
- Threshold outputs are constant from their parameters and are also their reset values.
- Reset (asynchronous, resetCore low):
  - state = IDLE, lastGrant = 3, grantIdx = 0, beatCnt = 0.
  - fifoPush = 0, fifoDataIn = 0, errOverrun = errUnderrun = 0, reqReady = 0.
  - A burst in progress is dropped. An entry already registered for push is discarded.

## Timing
- Grant latency: 1 cycle from reqValid (in IDLE) to reqReady.
- Push latency: 1 cycle from accept to fifoPush.
- One IDLE bubble cycle between consecutive bursts.
- Peak throughput: BURST_MAX beats per BURST_MAX+1 cycles.
- reqData must be stable while reqValid is high and the accept has not yet occurred. A requester must not drop reqValid without an accept. A drop is legal only as end-of-burst, and is treated as that.
- Reset deassertion is synchronised externally. The first active edge after release may perform IDLE arbitration.

## Test plan
- Reset: assert resetCore low mid-burst with fifoPush = 1 -> all outputs 0 immediately, thresholds read 14 and 2. After release with all reqValid high, requester 0 is granted first.
- Single requester: reqValid = 4'b0100 for 10 entries, FIFO draining -> accept pattern is 4 beats, 1 bubble, 4 beats, 1 bubble, 2 beats. fifoDataIn[27:26] = 2'b10 on every push, and each push is 1 cycle after its accept.
- Fairness: all four requesters continuously valid -> grant order 0,1,2,3,0,... with 4 beats each. Source IDs on fifoDataIn follow the same order.
- Early drop: requester 1 deasserts reqValid after 2 accepts while requester 3 is valid -> IDLE for 1 cycle, then requester 3 is granted. The next arbitration with all valid starts at 2.
- Throttle: no pops, requester 0 always valid -> exactly 16 pushes and then reqReady stays low, with fifoOverrun never asserted. One pop reopens exactly one accept.
- Errors: pulse fifoUnderrun -> errUnderrun high and held. errClear together with a new pulse -> stays high. errClear alone -> clears next cycle.
